// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory front-end.
package imem_pkg;

  localparam int IMEM_RD_LAT = 3;
  localparam int IMEM_WR_LAT = 2;
  localparam int IMEM_ADDR_W = 21;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_TAG_W  = IMEM_ADDR_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_RD = 3'd1,
    ST_WAIT_RD  = 3'd2,
    ST_RESP     = 3'd3,
    ST_ISSUE_WR = 3'd4,
    ST_WAIT_WR  = 3'd5,
    ST_HIT_RESP = 3'd6
  } imem_state_e;

  // Word-align a byte address (the controller only sees whole words).
  function automatic logic [IMEM_ADDR_W-1:0] word_addr(input logic [IMEM_ADDR_W-1:0] a);
    return {a[IMEM_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Fetch, loader and SRAM-controller bus bundle for the fetch arbiter.
interface imem_fetch_arbiter_if;
  import imem_pkg::*;

  logic                   if_req;
  logic [IMEM_ADDR_W-1:0] if_addr;
  logic                   if_ready;
  logic                   if_rvalid;
  logic [IMEM_DATA_W-1:0] if_rdata;

  logic                   ld_req;
  logic [IMEM_ADDR_W-1:0] ld_addr;
  logic [IMEM_DATA_W-1:0] ld_wdata;
  logic                   ld_ready;
  logic                   ld_done;

  logic                   mem_wr_en;
  logic                   mem_rd_en;
  logic [IMEM_ADDR_W-1:0] mem_addr;
  logic [IMEM_DATA_W-1:0] mem_wr_data;
  logic [IMEM_DATA_W-1:0] mem_rd_data;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, ld_wdata, mem_rd_data,
    output if_ready, if_rvalid, if_rdata, ld_ready, ld_done,
           mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );

  // Requester / controller side
  modport master (
    output if_req, if_addr, ld_req, ld_addr, ld_wdata, mem_rd_data,
    input  if_ready, if_rvalid, if_rdata, ld_ready, ld_done,
           mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );

endinterface

// File: rtl/imem_fetch_buf.sv
// One-word fetch buffer: tag/data/valid, hit compare, and write-through update
// so a loader write to the buffered word never leaves stale data behind.
module imem_fetch_buf
  import imem_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IMEM_TAG_W-1:0] lookup_tag,
  output logic                  hit,
  output logic [IMEM_DATA_W-1:0] rd_data,
  input  logic                  fill_en,
  input  logic [IMEM_TAG_W-1:0] fill_tag,
  input  logic [IMEM_DATA_W-1:0] fill_data,
  input  logic                  upd_en,
  input  logic [IMEM_TAG_W-1:0] upd_tag,
  input  logic [IMEM_DATA_W-1:0] upd_data
);

  logic                   valid_q, valid_d;
  logic [IMEM_TAG_W-1:0]  tag_q, tag_d;
  logic [IMEM_DATA_W-1:0] data_q, data_d;

  // Fill on read completion; patch data when a committed write hits the tag.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end else if (upd_en && valid_q && (upd_tag == tag_q)) begin
      data_d  = upd_data;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit     = EN && valid_q && (tag_q == lookup_tag);
  assign rd_data = data_q;

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Instruction-memory front-end: loader writes win over CPU fetches, one 32-bit
// access in flight at a time, with a one-word fetch buffer short-circuiting
// repeat fetches. RD_LAT must be >= 2 and WR_LAT >= 1.
module imem_fetch_arbiter
  import imem_pkg::*;
#(
  parameter int RD_LAT     = IMEM_RD_LAT,
  parameter int WR_LAT     = IMEM_WR_LAT,
  parameter bit HIT_BUF_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_fetch_arbiter_if.slave   bus,
  output logic                  busy
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  imem_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic                   mem_wr_en_q, mem_wr_en_d;
  logic [IMEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [IMEM_DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                   if_rvalid_q, if_rvalid_d;
  logic [IMEM_DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic                   ld_done_q, ld_done_d;

  logic                   buf_hit, fill_en, upd_en;
  logic [IMEM_DATA_W-1:0] buf_data;

  imem_fetch_buf #(.EN(HIT_BUF_EN)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (bus.if_addr[IMEM_ADDR_W-1:2]),
    .hit        (buf_hit),
    .rd_data    (buf_data),
    .fill_en    (fill_en),
    .fill_tag   (mem_addr_q[IMEM_ADDR_W-1:2]),
    .fill_data  (bus.mem_rd_data),
    .upd_en     (upd_en),
    .upd_tag    (mem_addr_q[IMEM_ADDR_W-1:2]),
    .upd_data   (mem_wr_data_q)
  );

  // Next-state and registered-output logic. The strobe cycle counts as latency
  // cycle 1; RESP is the last latency cycle, whose closing edge captures
  // mem_rd_data, so the if_rvalid cycle is already IDLE and can accept again.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    if_rvalid_d   = 1'b0;
    if_rdata_d    = if_rdata_q;
    ld_done_d     = 1'b0;
    fill_en       = 1'b0;
    upd_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ld_req) begin
          state_d       = ST_ISSUE_WR;
          mem_wr_en_d   = 1'b1;
          mem_addr_d    = word_addr(bus.ld_addr);
          mem_wr_data_d = bus.ld_wdata;
        end else if (bus.if_req) begin
          if (buf_hit) begin
            state_d     = ST_HIT_RESP;
            if_rvalid_d = 1'b1;
            if_rdata_d  = buf_data;
          end else begin
            state_d     = ST_ISSUE_RD;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = word_addr(bus.if_addr);
          end
        end
      end
      ST_ISSUE_RD: begin
        cnt_d   = CNT_W'(1);
        state_d = (RD_LAT <= 2) ? ST_RESP : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (int'(cnt_q) + 1 >= RD_LAT - 1) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        if_rvalid_d = 1'b1;
        if_rdata_d  = bus.mem_rd_data;
        fill_en     = 1'b1;
      end
      ST_ISSUE_WR: begin
        cnt_d = CNT_W'(1);
        if (WR_LAT <= 1) begin
          state_d   = ST_IDLE;
          ld_done_d = 1'b1;
          upd_en    = 1'b1;
        end else begin
          state_d   = ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (int'(cnt_q) + 1 >= WR_LAT) begin
          state_d   = ST_IDLE;
          ld_done_d = 1'b1;
          upd_en    = 1'b1;
        end
      end
      ST_HIT_RESP: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      if_rvalid_q   <= 1'b0;
      if_rdata_q    <= '0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      if_rvalid_q   <= if_rvalid_d;
      if_rdata_q    <= if_rdata_d;
      ld_done_q     <= ld_done_d;
    end
  end

  // Readies are held low during reset so every output reads 0 there.
  assign bus.ld_ready    = rst_n && (state_q == ST_IDLE);
  assign bus.if_ready    = bus.ld_ready && !bus.ld_req;
  assign bus.if_rvalid   = if_rvalid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.ld_done     = ld_done_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: a cycle-by-cycle vector table for the
// main traffic patterns, then a hand-written reset-during-read sequence.
module tb_imem_fetch_arbiter;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  imem_fetch_arbiter_if bus();

  imem_fetch_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Output bundle: if_ready ld_ready if_rvalid if_rdata ld_done busy rd_en wr_en mem_addr mem_wr_data
  typedef logic [91:0] obs_t;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [20:0] ia;
    logic        lr;
    logic [20:0] la;
    logic [31:0] lw;
    logic [31:0] rd;
    obs_t        exp;
  } vec_t;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] W1 = 32'h12345678;
  localparam logic [31:0] W2 = 32'hAAAA5555;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] A0 = 32'h0000A0A0;
  localparam logic [31:0] F4 = 32'h44444444;

  vec_t tbl[28];

  function automatic vec_t v(input logic rst, ir, input logic [20:0] ia, input logic lr,
                             input logic [20:0] la, input logic [31:0] lw, rd,
                             input logic iry, lry, rv, input logic [31:0] rdat,
                             input logic dn, bsy, re, we, input logic [20:0] ma,
                             input logic [31:0] mwd);
    vec_t r;
    r.rst = rst; r.ir = ir; r.ia = ia; r.lr = lr; r.la = la; r.lw = lw; r.rd = rd;
    r.exp = {iry, lry, rv, rdat, dn, bsy, re, we, ma, mwd};
    return r;
  endfunction

  function automatic obs_t outs();
    return {bus.if_ready, bus.ld_ready, bus.if_rvalid, bus.if_rdata, bus.ld_done, busy,
            bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, ir, input logic [20:0] ia, input logic lr,
                       input logic [20:0] la, input logic [31:0] lw, rd);
    rst_n = rst; bus.if_req = ir; bus.if_addr = ia; bus.ld_req = lr;
    bus.ld_addr = la; bus.ld_wdata = lw; bus.mem_rd_data = rd;
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);

    //          rst ir ia      lr la      lw  rd     iry lry rv rdata dn bsy re we ma      mwd
    tbl[0]  = v(0,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, 0,    0, 0,  0, 0, 21'h0,  0);
    tbl[1]  = v(1,  1, 21'h10, 0, 21'h0,  0,  0,     1,  1,  0, 0,    0, 0,  0, 0, 21'h0,  0);
    tbl[2]  = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, 0,    0, 1,  1, 0, 21'h10, 0);
    tbl[3]  = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, 0,    0, 1,  0, 0, 21'h10, 0);
    tbl[4]  = v(1,  0, 21'h0,  0, 21'h0,  0,  DB,    0,  0,  0, 0,    0, 1,  0, 0, 21'h10, 0);
    tbl[5]  = v(1,  1, 21'h12, 0, 21'h0,  0,  0,     1,  1,  1, DB,   0, 0,  0, 0, 21'h10, 0);
    tbl[6]  = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  1, DB,   0, 1,  0, 0, 21'h10, 0);
    tbl[7]  = v(1,  0, 21'h0,  1, 21'h10, W1, 0,     0,  1,  0, DB,   0, 0,  0, 0, 21'h10, 0);
    tbl[8]  = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, DB,   0, 1,  0, 1, 21'h10, W1);
    tbl[9]  = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, DB,   0, 1,  0, 0, 21'h10, W1);
    tbl[10] = v(1,  1, 21'h10, 0, 21'h0,  0,  0,     1,  1,  0, DB,   1, 0,  0, 0, 21'h10, W1);
    tbl[11] = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  1, W1,   0, 1,  0, 0, 21'h10, W1);
    tbl[12] = v(1,  1, 21'h100,1, 21'h40, W2, 0,     0,  1,  0, W1,   0, 0,  0, 0, 21'h10, W1);
    tbl[13] = v(1,  1, 21'h100,0, 21'h0,  0,  0,     0,  0,  0, W1,   0, 1,  0, 1, 21'h40, W2);
    tbl[14] = v(1,  1, 21'h100,0, 21'h0,  0,  0,     0,  0,  0, W1,   0, 1,  0, 0, 21'h40, W2);
    tbl[15] = v(1,  1, 21'h100,0, 21'h0,  0,  0,     1,  1,  0, W1,   1, 0,  0, 0, 21'h40, W2);
    tbl[16] = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, W1,   0, 1,  1, 0, 21'h100,W2);
    tbl[17] = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, W1,   0, 1,  0, 0, 21'h100,W2);
    tbl[18] = v(1,  0, 21'h0,  0, 21'h0,  0,  CF,    0,  0,  0, W1,   0, 1,  0, 0, 21'h100,W2);
    tbl[19] = v(1,  1, 21'h0,  0, 21'h0,  0,  0,     1,  1,  1, CF,   0, 0,  0, 0, 21'h100,W2);
    tbl[20] = v(1,  1, 21'h4,  0, 21'h0,  0,  0,     0,  0,  0, CF,   0, 1,  1, 0, 21'h0,  W2);
    tbl[21] = v(1,  1, 21'h4,  0, 21'h0,  0,  0,     0,  0,  0, CF,   0, 1,  0, 0, 21'h0,  W2);
    tbl[22] = v(1,  1, 21'h4,  0, 21'h0,  0,  A0,    0,  0,  0, CF,   0, 1,  0, 0, 21'h0,  W2);
    tbl[23] = v(1,  1, 21'h4,  0, 21'h0,  0,  0,     1,  1,  1, A0,   0, 0,  0, 0, 21'h0,  W2);
    tbl[24] = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, A0,   0, 1,  1, 0, 21'h4,  W2);
    tbl[25] = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     0,  0,  0, A0,   0, 1,  0, 0, 21'h4,  W2);
    tbl[26] = v(1,  0, 21'h0,  0, 21'h0,  0,  F4,    0,  0,  0, A0,   0, 1,  0, 0, 21'h4,  W2);
    tbl[27] = v(1,  0, 21'h0,  0, 21'h0,  0,  0,     1,  1,  1, F4,   0, 0,  0, 0, 21'h4,  W2);

    #3;
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].lr, tbl[i].la, tbl[i].lw, tbl[i].rd);
      #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      tick();
    end

    // Reset while a read is in WAIT_RD: access abandoned, buffer cleared.
    drive(1'b1, 1'b1, 21'h8, 1'b0, '0, '0, 32'h8888_0008);
    #1; chk("rst_seq_accept", obs_t'(bus.if_ready), obs_t'(1));
    tick();
    bus.if_req = 1'b0;
    #1; chk("rst_seq_strobe", obs_t'(bus.mem_rd_en), obs_t'(1));
    tick();
    chk("rst_seq_waitrd", obs_t'({busy, bus.mem_rd_en, bus.if_rvalid}), obs_t'(3'b100));
    rst_n = 1'b0;
    #1; chk("rst_mid_read_outs", outs(), '0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.if_rvalid || bus.ld_done || bus.mem_rd_en || busy) n++;
      tick();
    end
    chk("rst_no_resp", obs_t'(n), '0);

    // Same address again must miss: strobe at c+1, data at c+4.
    bus.if_req = 1'b1; bus.if_addr = 21'h8;
    #1; chk("refetch_accept", obs_t'(bus.if_ready), obs_t'(1));
    tick();
    bus.if_req = 1'b0;
    #1; chk("refetch_miss_strobe", obs_t'({bus.mem_rd_en, bus.mem_addr}), obs_t'({1'b1, 21'h8}));
    n = 0;
    while (!bus.if_rvalid && n < 10) begin
      tick();
      n++;
    end
    chk("refetch_latency", obs_t'(n), obs_t'(3));
    chk("refetch_data", obs_t'(bus.if_rdata), obs_t'(32'h8888_0008));
    tick();

    // Now it is buffered: hit at c+1 without a strobe.
    bus.if_req = 1'b1; bus.if_addr = 21'h9; bus.mem_rd_data = '0;
    #1; tick();
    bus.if_req = 1'b0;
    #1; chk("rehit", obs_t'({bus.if_rvalid, bus.if_rdata, bus.mem_rd_en}),
            obs_t'({1'b1, 32'h8888_0008, 1'b0}));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
